// File: rtl/dice_turn_ctrl.sv
// dice_turn_ctrl: turn sequencer for the two-player dice game.
// It decides which die rolls and when a roll stops, latches each player's
// result, scores each round and declares the match winner.
//
// Handshake note: this block has no valid/ready channels. btn1/btn2 are
// one-clk press pulses that are consumed only in the clk they arrive, and
// only when the current state owns that button. There is no pending-press
// memory. tick is a one-clk enable pulse and is never back-pressured.

module dice_turn_ctrl #(
  parameter int ROUNDS     = 5,    // rounds per match (1..15)
  parameter int ROLL_TICKS = 50,   // minimum roll time before a stop press counts
  parameter int SHOW_TICKS = 200   // ticks a latched result is shown
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn1,
  input  logic       btn2,
  input  logic [3:0] dice1,
  input  logic [3:0] dice2,
  output logic       roll_en1,
  output logic       roll_en2,
  output logic [3:0] held1,
  output logic [3:0] held2,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [3:0] round_cnt,
  output logic       round_done,
  output logic       finish,
  output logic [1:0] winner
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_P1_WAIT = 4'd1,
    S_P1_ROLL = 4'd2,
    S_P1_SHOW = 4'd3,
    S_P2_WAIT = 4'd4,
    S_P2_ROLL = 4'd5,
    S_P2_SHOW = 4'd6,
    S_COMPARE = 4'd7,
    S_FINAL   = 4'd8
  } state_t;

  localparam logic [9:0] ROLL_T  = 10'(ROLL_TICKS);
  localparam logic [9:0] SHOW_T  = 10'(SHOW_TICKS);
  localparam logic [9:0] TCNT_MX = 10'd1023;
  localparam logic [3:0] RND     = 4'(ROUNDS);
  localparam logic [3:0] WIN_AT  = 4'(ROUNDS / 2 + 1);

  // State is kept as a plain named register so checkers can bind to it.
  state_t     state_q, state_d;
  logic [9:0] tcnt_q, tcnt_d;
  logic       roll_en1_q, roll_en1_d;
  logic       roll_en2_q, roll_en2_d;
  logic [3:0] held1_q, held1_d;
  logic [3:0] held2_q, held2_d;
  logic [3:0] score1_q, score1_d;
  logic [3:0] score2_q, score2_d;
  logic [3:0] round_cnt_q, round_cnt_d;
  logic       round_done_q, round_done_d;

  // Round-result helpers used by COMPARE.
  logic       p1_wins, p2_wins;
  logic [3:0] score1_nx, score2_nx, round_nx;
  logic       match_over;
  logic       tcnt_counting;
  logic       p1_stop_ok, p2_stop_ok;

  // Out-of-range die values (0, 7..15) are latched as 0 so they always lose.
  function automatic logic [3:0] die_clean(input logic [3:0] v);
    return ((v >= 4'd1) && (v <= 4'd6)) ? v : 4'd0;
  endfunction

  // Round scoring and match-end decision, all saturating at ROUNDS.
  always_comb begin
    p1_wins    = held1_q > held2_q;
    p2_wins    = held2_q > held1_q;
    score1_nx  = (p1_wins && (score1_q != RND)) ? score1_q + 4'd1 : score1_q;
    score2_nx  = (p2_wins && (score2_q != RND)) ? score2_q + 4'd1 : score2_q;
    round_nx   = (round_cnt_q != RND) ? round_cnt_q + 4'd1 : round_cnt_q;
    match_over = (round_nx == RND) || (score1_nx >= WIN_AT) || (score2_nx >= WIN_AT);
    // Stop presses look at tcnt before any tick arriving in the same clk.
    p1_stop_ok = btn1 && (tcnt_q >= ROLL_T);
    p2_stop_ok = btn2 && (tcnt_q >= ROLL_T);
  end

  // Next-state logic; only the button owned by the current state is looked at.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (btn1)             state_d = S_P1_ROLL;
      S_P1_WAIT: if (btn1)             state_d = S_P1_ROLL;
      S_P1_ROLL: if (p1_stop_ok)       state_d = S_P1_SHOW;
      S_P1_SHOW: if (tcnt_q == SHOW_T) state_d = S_P2_WAIT;
      S_P2_WAIT: if (btn2)             state_d = S_P2_ROLL;
      S_P2_ROLL: if (p2_stop_ok)       state_d = S_P2_SHOW;
      S_P2_SHOW: if (tcnt_q == SHOW_T) state_d = S_COMPARE;
      S_COMPARE: state_d = match_over ? S_FINAL : S_P1_WAIT;
      S_FINAL:   if (btn1)             state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Shared tick counter: cleared on every state entry, counts ticks in the
  // roll and show states, saturates at its maximum.
  always_comb begin
    tcnt_counting = (state_q == S_P1_ROLL) || (state_q == S_P2_ROLL) ||
                    (state_q == S_P1_SHOW) || (state_q == S_P2_SHOW);
    tcnt_d = tcnt_q;
    if (state_d != state_q) begin
      tcnt_d = 10'd0;
    end else if (tcnt_counting && tick && (tcnt_q != TCNT_MX)) begin
      tcnt_d = tcnt_q + 10'd1;
    end
  end

  // Datapath: result latching, scoring and the match-reset clear.
  always_comb begin
    roll_en1_d   = (state_d == S_P1_ROLL);
    roll_en2_d   = (state_d == S_P2_ROLL);
    held1_d      = held1_q;
    held2_d      = held2_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    round_cnt_d  = round_cnt_q;
    round_done_d = 1'b0;
    unique case (state_q)
      S_P1_ROLL: if (state_d == S_P1_SHOW) held1_d = die_clean(dice1);
      S_P2_ROLL: if (state_d == S_P2_SHOW) held2_d = die_clean(dice2);
      S_COMPARE: begin
        score1_d     = score1_nx;
        score2_d     = score2_nx;
        round_cnt_d  = round_nx;
        round_done_d = 1'b1;
      end
      S_FINAL: begin
        if (state_d == S_IDLE) begin
          held1_d     = 4'd0;
          held2_d     = 4'd0;
          score1_d    = 4'd0;
          score2_d    = 4'd0;
          round_cnt_d = 4'd0;
        end
      end
      default: begin
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tcnt_q       <= 10'd0;
      roll_en1_q   <= 1'b0;
      roll_en2_q   <= 1'b0;
      held1_q      <= 4'd0;
      held2_q      <= 4'd0;
      score1_q     <= 4'd0;
      score2_q     <= 4'd0;
      round_cnt_q  <= 4'd0;
      round_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      roll_en1_q   <= roll_en1_d;
      roll_en2_q   <= roll_en2_d;
      held1_q      <= held1_d;
      held2_q      <= held2_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      round_cnt_q  <= round_cnt_d;
      round_done_q <= round_done_d;
    end
  end

  // Match result, meaningful only while FINAL; cleared together with the scores.
  always_comb begin
    winner = 2'd0;
    if (state_q == S_FINAL) begin
      if (score1_q > score2_q)      winner = 2'd1;
      else if (score2_q > score1_q) winner = 2'd2;
      else                          winner = 2'd3;
    end
  end

  assign finish     = (state_q == S_FINAL);
  assign roll_en1   = roll_en1_q;
  assign roll_en2   = roll_en2_q;
  assign held1      = held1_q;
  assign held2      = held2_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign round_cnt  = round_cnt_q;
  assign round_done = round_done_q;

  // Only one roller may ever run.
  a_one_roller: assert property (@(posedge clk) disable iff (rst)
                                 !(roll_en1_q && roll_en2_q));

endmodule

// File: tb/tb_dice_turn_ctrl.sv
// Bench for dice_turn_ctrl with short timing parameters.
module tb_dice_turn_ctrl;

  localparam int ROUNDS     = 3;
  localparam int ROLL_TICKS = 4;
  localparam int SHOW_TICKS = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       btn1;
  logic       btn2;
  logic [3:0] dice1;
  logic [3:0] dice2;
  logic       roll_en1;
  logic       roll_en2;
  logic [3:0] held1;
  logic [3:0] held2;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [3:0] round_cnt;
  logic       round_done;
  logic       finish;
  logic [1:0] winner;

  int total = 0;
  int bad   = 0;

  // Expected {held1, held2, score1, score2, round_cnt} per round_done pulse.
  logic [19:0] exp_q[$];
  logic [19:0] mon_got, mon_exp;

  // Reference model of the match.
  int         m_s1, m_s2, m_r;
  logic [3:0] last_h1;

  dice_turn_ctrl #(
    .ROUNDS    (ROUNDS),
    .ROLL_TICKS(ROLL_TICKS),
    .SHOW_TICKS(SHOW_TICKS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .btn1      (btn1),
    .btn2      (btn2),
    .dice1     (dice1),
    .dice2     (dice2),
    .roll_en1  (roll_en1),
    .roll_en2  (roll_en2),
    .held1     (held1),
    .held2     (held2),
    .score1    (score1),
    .score2    (score2),
    .round_cnt (round_cnt),
    .round_done(round_done),
    .finish    (finish),
    .winner    (winner)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask

  task automatic press(input logic b1, input logic b2);
    btn1 = b1;
    btn2 = b2;
    step();
    btn1 = 1'b0;
    btn2 = 1'b0;
  endtask

  function automatic logic [3:0] model_die(input logic [3:0] v);
    return ((v >= 4'd1) && (v <= 4'd6)) ? v : 4'd0;
  endfunction

  function automatic logic [25:0] all_outs();
    return {roll_en1, roll_en2, held1, held2, score1, score2, round_cnt,
            round_done, finish, winner};
  endfunction

  task automatic model_clear();
    m_s1 = 0;
    m_s2 = 0;
    m_r  = 0;
  endtask

  // Full player-1 turn ending in P2_WAIT.
  task automatic roll_p1(input logic [3:0] d1);
    press(1'b1, 1'b0);
    ticks(ROLL_TICKS);
    dice1 = d1;
    press(1'b1, 1'b0);
    last_h1 = model_die(d1);
    ticks(SHOW_TICKS);
    step();
  endtask

  // Full player-2 turn through COMPARE; pushes the expected round result.
  task automatic roll_p2(input logic [3:0] d2, input logic both);
    logic [3:0] h2;
    int         waited;
    press(both, 1'b1);
    total++;
    if ({roll_en1, roll_en2} !== 2'b01) begin
      bad++;
      $display("FAIL p2_start: roll_en1/roll_en2=%b expected 01", {roll_en1, roll_en2});
    end
    ticks(ROLL_TICKS);
    dice2 = d2;
    h2 = model_die(d2);
    if (last_h1 > h2) m_s1++;
    else if (h2 > last_h1) m_s2++;
    m_r++;
    exp_q.push_back({last_h1, h2, 4'(m_s1), 4'(m_s2), 4'(m_r)});
    press(1'b0, 1'b1);
    ticks(SHOW_TICKS);
    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      step();
      waited++;
    end
    step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL round_done_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (round_done === 1'b1) begin
      total++;
      mon_got = {held1, held2, score1, score2, round_cnt};
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL round_done_extra: got h1/h2/s1/s2/rc=%h with nothing expected", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          bad++;
          $display("FAIL round_result: h1/h2/s1/s2/rc got %h expected %h", mon_got, mon_exp);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if (all_outs() !== 26'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    rst = 1'b0;
    model_clear();
    step();
  endtask

  task automatic test_p1_roll();
    press(1'b1, 1'b0);
    total++;
    if ({roll_en1, roll_en2} !== 2'b10) begin
      bad++;
      $display("FAIL p1_start: roll_en1/roll_en2=%b expected 10", {roll_en1, roll_en2});
    end
    ticks(2);
    press(1'b1, 1'b0);
    total++;
    if (roll_en1 !== 1'b1 || held1 !== 4'd0) begin
      bad++;
      $display("FAIL early_stop: roll_en1=%b held1=%0d expected 1 and 0", roll_en1, held1);
    end
    press(1'b0, 1'b1);
    total++;
    if ({roll_en1, roll_en2} !== 2'b10) begin
      bad++;
      $display("FAIL btn2_in_p1_roll: roll_en1/roll_en2=%b expected 10", {roll_en1, roll_en2});
    end
    ticks(ROLL_TICKS - 2);
    dice1 = 4'd5;
    press(1'b1, 1'b0);
    last_h1 = 4'd5;
    total++;
    if (held1 !== 4'd5 || roll_en1 !== 1'b0) begin
      bad++;
      $display("FAIL p1_stop: held1=%0d roll_en1=%b expected 5 and 0", held1, roll_en1);
    end
    ticks(SHOW_TICKS - 1);
    press(1'b0, 1'b1);
    total++;
    if (roll_en2 !== 1'b0) begin
      bad++;
      $display("FAIL btn2_in_show: roll_en2=%b expected 0", roll_en2);
    end
    ticks(1);
    step();
  endtask

  task automatic test_round();
    roll_p2(4'd3, 1'b0);
    total++;
    if (finish !== 1'b0) begin
      bad++;
      $display("FAIL round1_finish: finish=%b expected 0", finish);
    end
  endtask

  task automatic test_tie();
    roll_p1(4'd4);
    roll_p2(4'd4, 1'b0);
  endtask

  task automatic test_final_draw();
    roll_p1(4'd2);
    roll_p2(4'd6, 1'b0);
    total++;
    if (finish !== 1'b1 || winner !== 2'd3) begin
      bad++;
      $display("FAIL final_draw: finish=%b winner=%0d expected 1 and 3", finish, winner);
    end
    press(1'b1, 1'b0);
    model_clear();
    total++;
    if (all_outs() !== 26'd0) begin
      bad++;
      $display("FAIL clear_after_draw: got %h expected 0", all_outs());
    end
  endtask

  task automatic test_early_finish();
    roll_p1(4'd6);
    roll_p2(4'd1, 1'b0);
    total++;
    if (finish !== 1'b0) begin
      bad++;
      $display("FAIL early_r1_finish: finish=%b expected 0", finish);
    end
    roll_p1(4'd5);
    roll_p2(4'd2, 1'b0);
    total++;
    if (finish !== 1'b1 || winner !== 2'd1 || round_cnt !== 4'd2) begin
      bad++;
      $display("FAIL early_finish: finish=%b winner=%0d round_cnt=%0d expected 1,1,2",
               finish, winner, round_cnt);
    end
    press(1'b0, 1'b1);
    total++;
    if (finish !== 1'b1 || roll_en2 !== 1'b0) begin
      bad++;
      $display("FAIL btn2_in_final: finish=%b roll_en2=%b expected 1 and 0", finish, roll_en2);
    end
    press(1'b1, 1'b0);
    model_clear();
    total++;
    if (all_outs() !== 26'd0) begin
      bad++;
      $display("FAIL clear_after_win: got %h expected 0", all_outs());
    end
  endtask

  task automatic test_contention();
    roll_p1(4'd1);
    roll_p2(4'd7, 1'b1);
  endtask

  task automatic test_async_reset();
    roll_p1(4'(($urandom_range(1, 6))));
    press(1'b0, 1'b1);
    ticks(2);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (all_outs() !== 26'd0) begin
      bad++;
      $display("FAIL async_reset: got %h expected 0 before next edge", all_outs());
    end
    step();
    rst = 1'b0;
    model_clear();
    press(1'b0, 1'b1);
    total++;
    if ({roll_en1, roll_en2} !== 2'b00) begin
      bad++;
      $display("FAIL btn2_in_idle: roll_en1/roll_en2=%b expected 00", {roll_en1, roll_en2});
    end
    press(1'b1, 1'b0);
    total++;
    if ({roll_en1, roll_en2} !== 2'b10) begin
      bad++;
      $display("FAIL idle_restart: roll_en1/roll_en2=%b expected 10", {roll_en1, roll_en2});
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst   = 1'b1;
    tick  = 1'b0;
    btn1  = 1'b0;
    btn2  = 1'b0;
    dice1 = 4'd1;
    dice2 = 4'd1;
    last_h1 = 4'd0;
    model_clear();
    test_reset();
    test_p1_roll();
    test_round();
    test_tie();
    test_final_draw();
    test_early_finish();
    test_contention();
    test_async_reset();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
